tmr_add_sequencer: RTL and testbench
====================================

Name: tmr_add_sequencer

Overview:
Time-redundant sequencer for the 3-bit add/subtract datapath. It accepts one operation over a valid/ready handshake and checks input parity and the one-hot control word. A single shared adder then runs the operation three times: pass 0 direct, pass 1 with the adder ports swapped, pass 2 direct. It 2-of-3 votes {cout,sum}, reports a 2-bit error code and keeps saturating counts of corrected and uncorrectable events. A fault-injection port lets the bench corrupt individual pass results.

Parameters:
WIDTH, 3, operand/sum width
CNT_W, 8, width of each saturating event counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_par  in  1  parity bit; XOR of req_a, req_b and req_par must be 1 (odd)
req_ctrl  in  3  one-hot op: 001 ADD a+b; 010 SUB a+~b+1; 100 RSUB ~a+b+1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_sum  out  WIDTH  voted sum
rsp_cout  out  1  voted carry-out
rsp_err  out  2  00 ok; 01 corrected; 10 uncorrectable; 11 input check fail
inj_mask  in  3*(WIDTH+1)  segment k XORed into the stored {cout,sum} of pass k
cnt_clr  in  1  synchronous clear of both counters
corr_cnt  out  CNT_W  saturating count of err=01 responses
uncorr_cnt  out  CNT_W  saturating count of err=10 and err=11 responses

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; req_ready=1; rsp_valid=0; rsp_sum=0; rsp_cout=0; rsp_err=00; both counters=0; pass registers=0. Reset mid-operation aborts the operation with no response.
- States: IDLE, P0, P1, P2, RESP.
- IDLE:
  - A request is accepted at the edge where req_valid&req_ready; operands, ctrl and check result are captured.
  - Check fails (parity even, or ctrl not exactly one-hot, including 000) -> RESP next cycle with err=11, sum=0, cout=0.
  - Check passes -> P0.
- Adder operands:
  - opA = req_ctrl[2] ? ~a : a; opB = req_ctrl[1] ? ~b : b; cin = req_ctrl[1]|req_ctrl[2].
  - P0 and P2 drive adder (x=opA, y=opB, cin); P1 drives (x=opB, y=opA, cin).
  - Each pass registers {cout,sum} XOR its inj_mask segment, with inj_mask sampled in that pass's cycle.
- P0->P1->P2, one cycle each. At the P2 edge the block votes on r0, r1, r2 (r2 taken after its XOR) and registers the outputs, then enters RESP.
- Vote rule:
  - All three equal -> err=00, output r0.
  - Exactly two equal -> err=01, output the majority value.
  - All three differ -> err=10, output r0.
- Latency: accept at edge t; rsp_valid high from cycle t+4 (normal path) or t+1 (err=11).
- RESP:
  - rsp_valid=1; outputs held stable until rsp_valid&rsp_ready, then IDLE.
  - req_ready=0 in RESP, so there is no back-to-back accept.
  - Maximum throughput: one operation per 5 cycles with rsp_ready tied high.
- Counters:
  - Each increments exactly once, on the cycle RESP is entered, according to err.
  - Each saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Arithmetic is modulo 2^WIDTH. cout is the adder's raw carry (for SUB, cout=1 means no borrow).

Decomposition:
- Package tmr_pkg: state enum, op one-hot constants OP_ADD/OP_SUB/OP_RSUB, error code constants ERR_OK/ERR_CORR/ERR_UNCORR/ERR_INPUT.
- One sub-module: add_unit (WIDTH-bit ripple-carry adder built from full adders), instantiated once and shared across the three passes.
- Voter stays inline.

Test Plan:
- ADD a=3, b=2, par=0, ctrl=001, no injection -> rsp_valid at t+4, sum=5, cout=0, err=00, counters unchanged.
- SUB a=2, b=5, par=0, ctrl=010 -> sum=5, cout=0, err=00. RSUB a=5, b=2, par=0, ctrl=100 -> sum=5, cout=0, err=00.
- ADD a=7, b=7, par=1, pass-1 mask=0001 -> sum=6, cout=1, err=01, corr_cnt=1.
- ADD a=7, b=7, par=1, pass-1 mask=0001, pass-2 mask=0010 -> err=10, output = pass-0 value (sum=6, cout=1), uncorr_cnt=1.
- a=3, b=2, par=1 (even parity) -> err=11 at t+1, sum=0. ctrl=011 with valid parity -> err=11. uncorr_cnt +1 each time.
- Hold rsp_ready=0 for 10 cycles -> outputs stable, req_ready=0. Separately, rst_n=0 during P1 -> IDLE next cycle, rsp_valid=0, counters=0. Separately, drive 256 corrected events -> corr_cnt saturates at 255; cnt_clr together with an increment -> 0.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and constants for the time-redundant add/subtract sequencer.
package tmr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StP0,
    StP1,
    StP2,
    StResp
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_RSUB = 3'b100;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b10;
  localparam logic [1:0] ERR_INPUT  = 2'b11;

  function automatic logic op_valid(logic [2:0] ctrl);
    return (ctrl == OP_ADD) || (ctrl == OP_SUB) || (ctrl == OP_RSUB);
  endfunction

endpackage

// File: rtl/add_unit.sv
// WIDTH-bit ripple-carry adder built from full-adder cells.
module add_unit #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]     = x_i[i] ^ y_i[i] ^ carry[i];
    assign carry[i + 1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/tmr_add_sequencer.sv
// Runs one add/sub three times on a shared adder (direct, swapped, direct),
// votes the results 2-of-3 and counts corrected / uncorrectable events.
module tmr_add_sequencer
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic                     req_par,
  input  logic [2:0]               req_ctrl,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [1:0]               rsp_err,
  input  logic [3*(WIDTH+1)-1:0]   inj_mask,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt
);

  localparam int unsigned RW = WIDTH + 1;
  localparam logic [CNT_W-1:0] CntOne = 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             inv_a_q, inv_a_d, inv_b_q, inv_b_d;
  logic [RW-1:0]    r0_q, r0_d, r1_q, r1_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] corr_q, corr_d, unc_q, unc_d;

  logic [WIDTH-1:0] op_a, op_b, add_x, add_y, add_sum;
  logic             add_cin, add_cout;
  logic [RW-1:0]    pass_mask, pass_res;
  logic [RW-1:0]    vote_val;
  logic [1:0]       vote_err;
  logic             chk_ok, enter_resp;

  // Pass 1 swaps the adder ports so a stuck input lane shows up as a disagreement.
  always_comb begin
    op_a    = inv_a_q ? ~a_q : a_q;
    op_b    = inv_b_q ? ~b_q : b_q;
    add_cin = inv_a_q | inv_b_q;
    add_x   = (state_q == StP1) ? op_b : op_a;
    add_y   = (state_q == StP1) ? op_a : op_b;
  end

  add_unit #(
    .WIDTH (WIDTH)
  ) u_add (
    .x_i    (add_x),
    .y_i    (add_y),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    pass_mask = '0;
    unique case (state_q)
      StP0:    pass_mask = inj_mask[0 +: RW];
      StP1:    pass_mask = inj_mask[RW +: RW];
      StP2:    pass_mask = inj_mask[2*RW +: RW];
      default: pass_mask = '0;
    endcase
    pass_res = {add_cout, add_sum} ^ pass_mask;
  end

  // Voter: pass_res is r2 while in P2.
  always_comb begin
    vote_val = r0_q;
    vote_err = ERR_UNCORR;
    if (r0_q == r1_q && r1_q == pass_res) begin
      vote_err = ERR_OK;
    end else if (r0_q == r1_q || r0_q == pass_res) begin
      vote_err = ERR_CORR;
    end else if (r1_q == pass_res) begin
      vote_val = r1_q;
      vote_err = ERR_CORR;
    end
  end

  assign chk_ok = (^{req_a, req_b, req_par}) & op_valid(req_ctrl);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    inv_a_d = inv_a_q;
    inv_b_d = inv_b_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          inv_a_d = (req_ctrl == OP_RSUB);
          inv_b_d = (req_ctrl == OP_SUB);
          if (chk_ok) begin
            state_d = StP0;
          end else begin
            state_d = StResp;
            sum_d   = '0;
            cout_d  = 1'b0;
            err_d   = ERR_INPUT;
          end
        end
      end
      StP0: begin
        r0_d    = pass_res;
        state_d = StP1;
      end
      StP1: begin
        r1_d    = pass_res;
        state_d = StP2;
      end
      StP2: begin
        {cout_d, sum_d} = vote_val;
        err_d           = vote_err;
        state_d         = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_q != StResp) && (state_d == StResp);

  always_comb begin
    corr_d = corr_q;
    unc_d  = unc_q;
    if (cnt_clr) begin
      corr_d = '0;
      unc_d  = '0;
    end else if (enter_resp) begin
      if (err_d == ERR_CORR && corr_q != '1) corr_d = corr_q + CntOne;
      if ((err_d == ERR_UNCORR || err_d == ERR_INPUT) && unc_q != '1) unc_d = unc_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      inv_a_q <= 1'b0;
      inv_b_q <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= ERR_OK;
      corr_q  <= '0;
      unc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      inv_a_q <= inv_a_d;
      inv_b_q <= inv_b_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign rsp_err    = err_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = unc_q;

endmodule

// File: tb/tb_tmr_add_sequencer.sv
// Randomized and directed bench for tmr_add_sequencer against an arithmetic reference model.
module tb_tmr_add_sequencer;

  localparam int W  = 3;
  localparam int CW = 8;
  localparam int RW = W + 1;
  localparam int MW = 3 * RW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_a, req_b;
  logic          req_par;
  logic [2:0]    req_ctrl;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout;
  logic [1:0]    rsp_err;
  logic [MW-1:0] inj_mask;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt, uncorr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_corr = 0;
  int exp_unc  = 0;

  always #5 clk = ~clk;

  tmr_add_sequencer #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_par    (req_par),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_err    (rsp_err),
    .inj_mask   (inj_mask),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: true arithmetic result, each pass corrupted by its mask, then majority vote.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic par,
                                input logic [2:0] ctrl, input logic [MW-1:0] mask,
                                output int err, output int sum, output int cout);
    int m, x, y, cin, r, r0, r1, r2, v, mi;
    m  = (1 << W) - 1;
    mi = int'(mask);
    if ((^{a, b, par}) == 1'b0 || $countones(ctrl) != 1) begin
      err = 3; sum = 0; cout = 0;
      return;
    end
    x   = (ctrl == 3'b100) ? (~int'(a)) & m : int'(a);
    y   = (ctrl == 3'b010) ? (~int'(b)) & m : int'(b);
    cin = (ctrl == 3'b001) ? 0 : 1;
    r   = x + y + cin;
    r0  = r ^ (mi & 15);
    r1  = r ^ ((mi >> RW) & 15);
    r2  = r ^ ((mi >> (2 * RW)) & 15);
    if (r0 == r1 && r1 == r2) begin err = 0; v = r0; end
    else if (r0 == r1 || r0 == r2) begin err = 1; v = r0; end
    else if (r1 == r2) begin err = 1; v = r1; end
    else begin err = 2; v = r0; end
    sum  = v & m;
    cout = (v >> W) & 1;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic par,
                        input logic [2:0] ctrl, input logic [MW-1:0] mask, input int hold,
                        input bit clr, input bit full);
    int e_err, e_sum, e_cout, exp_lat, lat;
    model(a, b, par, ctrl, mask, e_err, e_sum, e_cout);
    exp_lat = (e_err == 3) ? 1 : 4;
    @(negedge clk);
    if (full) check_eq("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_par = par; req_ctrl = ctrl;
    inj_mask = mask; rsp_ready = 1'b0;
    if (clr && exp_lat == 1) cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      if (clr && lat == exp_lat - 1) cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      lat++;
    end
    cnt_clr = 1'b0;
    if (clr) begin
      exp_corr = 0; exp_unc = 0;
    end else if (e_err == 1) begin
      exp_corr = (exp_corr < CNT_MAX) ? exp_corr + 1 : CNT_MAX;
    end else if (e_err >= 2) begin
      exp_unc = (exp_unc < CNT_MAX) ? exp_unc + 1 : CNT_MAX;
    end
    if (full) begin
      check_eq("latency", 32'(lat), 32'(exp_lat));
      check_eq("rsp_valid", 32'(rsp_valid), 1);
      check_eq("rsp_sum", 32'(rsp_sum), 32'(e_sum));
      check_eq("rsp_cout", 32'(rsp_cout), 32'(e_cout));
      check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
      check_eq("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
      check_eq("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
    end else if (lat >= 12) begin
      check_eq("rsp_timeout", 32'(lat), 32'(exp_lat));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(rsp_valid), 1);
      check_eq("hold_ready", 32'(req_ready), 0);
      check_eq("hold_sum", 32'({rsp_err, rsp_cout, rsp_sum}),
               32'({2'(e_err), 1'(e_cout), 3'(e_sum)}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (full) begin
      check_eq("rsp_done", 32'(rsp_valid), 0);
      check_eq("back_idle", 32'(req_ready), 1);
    end
  endtask

  initial begin
    logic [2:0]    ctrl;
    logic [MW-1:0] mask;
    int            sel;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_par = 1'b0;
    req_ctrl = '0; rsp_ready = 1'b0; inj_mask = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp", 32'({rsp_err, rsp_cout, rsp_sum}), 0);
    check_eq("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd3, 3'd2, 1'b0, 3'b001, 12'h000, 0, 0, 1);
    run_op(3'd2, 3'd5, 1'b0, 3'b010, 12'h000, 0, 0, 1);
    run_op(3'd5, 3'd2, 1'b0, 3'b100, 12'h000, 0, 0, 1);
    run_op(3'd7, 3'd7, 1'b1, 3'b001, 12'h010, 0, 0, 1);
    run_op(3'd7, 3'd7, 1'b1, 3'b001, 12'h210, 0, 0, 1);
    run_op(3'd3, 3'd2, 1'b1, 3'b001, 12'h000, 0, 0, 1);
    run_op(3'd3, 3'd2, 1'b0, 3'b011, 12'h000, 0, 0, 1);
    run_op(3'd1, 3'd1, 1'b1, 3'b000, 12'h000, 0, 0, 1);
    run_op(3'd6, 3'd3, 1'b0, 3'b010, 12'h800, 10, 0, 1);
    run_op(3'd4, 3'd1, 1'b0, 3'b001, 12'h00f, 0, 0, 1);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 5);
      unique case (sel)
        0: ctrl = 3'b001;
        1: ctrl = 3'b010;
        2: ctrl = 3'b100;
        3: ctrl = 3'($urandom);
        default: ctrl = 3'b001 << $urandom_range(0, 2);
      endcase
      sel = $urandom_range(0, 4);
      unique case (sel)
        0, 1: mask = '0;
        2: mask = MW'(($urandom_range(1, 15)) << (RW * $urandom_range(0, 2)));
        3: mask = MW'($urandom_range(1, 15)) << RW | MW'($urandom_range(1, 15));
        default: mask = MW'($urandom);
      endcase
      run_op(3'($urandom), 3'($urandom), 1'($urandom), ctrl, mask, $urandom_range(0, 2), 0, 1);
    end

    // Reset while in P1 must abort with no response and clear counters.
    @(negedge clk);
    req_valid = 1'b1; req_a = 3'd1; req_b = 3'd2; req_par = 1'b1; req_ctrl = 3'b001;
    inj_mask = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_corr = 0; exp_unc = 0;
    check_eq("midrst_valid", 32'(rsp_valid), 0);
    check_eq("midrst_ready", 32'(req_ready), 1);
    check_eq("midrst_cnts", 32'({corr_cnt, uncorr_cnt}), 0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("midrst_no_rsp", 32'(rsp_valid), 0);

    // Saturation of the corrected-event counter, then clear racing an increment.
    for (int n = 0; n < 256; n++) run_op(3'd7, 3'd7, 1'b1, 3'b001, 12'h010, 0, 0, 0);
    check_eq("corr_sat", 32'(corr_cnt), 32'(CNT_MAX));
    run_op(3'd7, 3'd7, 1'b1, 3'b001, 12'h010, 0, 0, 1);
    run_op(3'd7, 3'd7, 1'b1, 3'b001, 12'h010, 0, 1, 1);
    run_op(3'd3, 3'd3, 1'b1, 3'b001, 12'h000, 0, 0, 1);
    run_op(3'd3, 3'd3, 1'b0, 3'b001, 12'h000, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
